// File: rtl/xxhash_idx_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xxhash_idx_pipe
// Purpose  : 4-stage valid/ready XXH32 (8-byte small-input path) index hasher
//            mapping (col,row,seed) to a bucket id with a sideband tag.
// Revision : 1.0  initial pipelined release
// ============================================================================
// PRIME32_1 only feeds the >=16-byte stripe path of XXH32 and is not needed
// for an 8-byte message, so it is not a parameter here.
module xxhash_idx_pipe #(
    parameter int          IDX_W     = 16,
    parameter int          OUT_W     = 5,
    parameter int          TAG_W     = 8,
    parameter logic [31:0] PRIME32_2 = 32'h85EBCA77,
    parameter logic [31:0] PRIME32_3 = 32'hC2B2AE3D,
    parameter logic [31:0] PRIME32_4 = 32'h27D4EB2F,
    parameter logic [31:0] PRIME32_5 = 32'h165667B1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] idx_col,
    input  logic [IDX_W-1:0] idx_row,
    input  logic [31:0]      seed,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] bucket,
    output logic [31:0]      hash,
    output logic [TAG_W-1:0] tag_out,
    output logic [31:0]      hash_cnt
);

    function automatic logic [31:0] rotl17(input logic [31:0] x);
        return {x[14:0], x[31:15]};
    endfunction

    logic [31:0] w_col_ext;
    logic [31:0] w_row_ext;
    logic        w_en;

    generate
        if (IDX_W < 32) begin : g_idx_pad
            assign w_col_ext = {{(32-IDX_W){1'b0}}, idx_col};
            assign w_row_ext = {{(32-IDX_W){1'b0}}, idx_row};
        end else begin : g_idx_full
            assign w_col_ext = idx_col;
            assign w_row_ext = idx_row;
        end
    endgenerate

    // Stage 1: captured transaction
    logic             s1_vld_q;
    logic [31:0]      s1_col_q;
    logic [31:0]      s1_row_q;
    logic [31:0]      s1_seed_q;
    logic [TAG_W-1:0] s1_tag_q;
    // Stage 2: accumulator after the col lane
    logic             s2_vld_q;
    logic [31:0]      s2_h_q;
    logic [31:0]      s2_h_d;
    logic [31:0]      s2_row_q;
    logic [TAG_W-1:0] s2_tag_q;
    // Stage 3: accumulator after the row lane
    logic             s3_vld_q;
    logic [31:0]      s3_h_q;
    logic [31:0]      s3_h_d;
    logic [TAG_W-1:0] s3_tag_q;
    // Stage 4: avalanched result held on the output
    logic             out_vld_q;
    logic [31:0]      hash_q;
    logic [31:0]      hash_d;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      cnt_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_en     = !out_vld_q || out_ready;
    assign in_ready = w_en;

    always_comb begin
        s2_h_d = rotl17(s1_seed_q + PRIME32_5 + 32'd8 + s1_col_q * PRIME32_3) * PRIME32_4;
        s3_h_d = rotl17(s2_h_q + s2_row_q * PRIME32_3) * PRIME32_4;
        hash_d = s3_h_q;
        hash_d = hash_d ^ (hash_d >> 15);
        hash_d = hash_d * PRIME32_2;
        hash_d = hash_d ^ (hash_d >> 13);
        hash_d = hash_d * PRIME32_3;
        hash_d = hash_d ^ (hash_d >> 16);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_col_q  <= '0;
            s1_row_q  <= '0;
            s1_seed_q <= '0;
            s1_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_h_q    <= '0;
            s2_row_q  <= '0;
            s2_tag_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_h_q    <= '0;
            s3_tag_q  <= '0;
            out_vld_q <= 1'b0;
            hash_q    <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (w_en) begin
                s1_vld_q  <= in_valid;
                s1_col_q  <= w_col_ext;
                s1_row_q  <= w_row_ext;
                s1_seed_q <= seed;
                s1_tag_q  <= tag_in;
                s2_vld_q  <= s1_vld_q;
                s2_h_q    <= s2_h_d;
                s2_row_q  <= s1_row_q;
                s2_tag_q  <= s1_tag_q;
                s3_vld_q  <= s2_vld_q;
                s3_h_q    <= s3_h_d;
                s3_tag_q  <= s2_tag_q;
                out_vld_q <= s3_vld_q;
                // Bubbles leave the last result on the outputs
                if (s3_vld_q) begin
                    hash_q <= hash_d;
                    tag_q  <= s3_tag_q;
                end
            end
            if (out_vld_q && out_ready) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign hash      = hash_q;
    assign bucket    = hash_q[OUT_W-1:0];
    assign tag_out   = tag_q;
    assign hash_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xxhash_idx_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xxhash_idx_pipe
// Purpose  : Scoreboarded random bench for xxhash_idx_pipe (default and
//            32/32/1 instances side by side) against a byte-level XXH32 model.
// Revision : 1.0  initial release
// ============================================================================
module tb_xxhash_idx_pipe;

    localparam logic [31:0] P2 = 32'h85EBCA77;
    localparam logic [31:0] P3 = 32'hC2B2AE3D;
    localparam logic [31:0] P4 = 32'h27D4EB2F;
    localparam logic [31:0] P5 = 32'h165667B1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] col32 = '0;
    logic [31:0] row32 = '0;
    logic [31:0] seed = '0;
    logic [7:0]  tag = '0;

    logic        a_in_ready, a_out_valid;
    logic [4:0]  a_bucket;
    logic [31:0] a_hash, a_hash_cnt;
    logic [7:0]  a_tag_out;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_bucket, b_hash, b_hash_cnt;
    logic [0:0]  b_tag_out;

    always #5 clk = ~clk;

    xxhash_idx_pipe dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .idx_col(col32[15:0]), .idx_row(row32[15:0]), .seed(seed), .tag_in(tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .bucket(a_bucket),
        .hash(a_hash), .tag_out(a_tag_out), .hash_cnt(a_hash_cnt)
    );

    xxhash_idx_pipe #(.IDX_W(32), .OUT_W(32), .TAG_W(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .idx_col(col32), .idx_row(row32), .seed(seed), .tag_in(tag[0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .bucket(b_bucket),
        .hash(b_hash), .tag_out(b_tag_out), .hash_cnt(b_hash_cnt)
    );

    typedef struct packed {
        logic [31:0] h;
        logic [7:0]  tag;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          bp_mode = 1'b0;
    bit          lat_mode = 1'b0;
    int          first_fire = -1;
    int          first_out = -1;
    int          last_out = -1;
    int          lat_outs = 0;
    logic [31:0] exp_cnt = '0;
    logic [31:0] exp_cnt_b = '0;
    bit          stalled_prev = 1'b0;
    logic [31:0] held_h;
    logic [7:0]  held_tag;

    // XXH32 small-input path over a little-endian byte buffer, as in the C reference
    function automatic logic [31:0] xxh32_8(input logic [31:0] c, input logic [31:0] r,
                                            input logic [31:0] s);
        byte unsigned buf8[8];
        logic [31:0]  h;
        logic [31:0]  lane;
        for (int i = 0; i < 4; i++) begin
            buf8[i]   = c[8*i +: 8];
            buf8[4+i] = r[8*i +: 8];
        end
        h = s + P5;
        h = h + 32'd8;
        for (int p = 0; p < 8; p += 4) begin
            lane = {buf8[p+3], buf8[p+2], buf8[p+1], buf8[p]};
            h = h + lane * P3;
            h = (h << 17) | (h >> 15);
            h = h * P4;
        end
        h = h ^ (h >> 15);
        h = h * P2;
        h = h ^ (h >> 13);
        h = h * P3;
        h = h ^ (h >> 16);
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    // Monitor, default instance: ordering, stall stability, handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            check("in_ready_rule", a_in_ready, !(a_out_valid && !out_ready));
            if (stalled_prev) begin
                check("stall_valid", a_out_valid, 1'b1);
                check("stall_hash", a_hash, held_h);
                check("stall_tag", a_tag_out, held_tag);
            end
            stalled_prev = a_out_valid && !out_ready;
            held_h       = a_hash;
            held_tag     = a_tag_out;
            if (a_out_valid && out_ready) begin
                exp_cnt = exp_cnt + 32'd1;
                if (lat_mode) begin
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    lat_outs++;
                end
                if (qa.size() == 0) begin
                    fail_now("a_unexpected_output");
                end else begin
                    e = qa.pop_front();
                    check("a_hash", a_hash, e.h);
                    check("a_bucket", a_bucket, e.h[4:0]);
                    check("a_tag", a_tag_out, e.tag);
                end
            end
        end
    end

    // Monitor, 32/32/1 instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_in_ready !== a_in_ready) fail_now("b_in_ready_differs");
            if (b_out_valid && out_ready) begin
                exp_cnt_b = exp_cnt_b + 32'd1;
                if (qb.size() == 0) begin
                    fail_now("b_unexpected_output");
                end else begin
                    e = qb.pop_front();
                    check("b_hash", b_hash, e.h);
                    check("b_bucket", b_bucket, e.h);
                    check("b_tag", b_tag_out, e.tag[0]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transaction fired
    task automatic send(input logic [31:0] c, input logic [31:0] r,
                        input logic [31:0] s, input logic [7:0] t);
        int w;
        bit fired;
        w = 0;
        fired = 1'b0;
        col32 = c; row32 = r; seed = s; tag = t; in_valid = 1'b1;
        while (!fired) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back('{h: xxh32_8(c & 32'hFFFF, r & 32'hFFFF, s), tag: t});
                qb.push_back('{h: xxh32_8(c, r, s), tag: {7'd0, t[0]}});
                if (lat_mode && first_fire < 0) first_fire = cyc;
                fired = 1'b1;
            end
            @(posedge clk);
            #1;
            w++;
            if (!fired && w > 1000) begin
                fail_now("send_timeout");
                fired = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        in_valid = 1'b0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (w >= 2000) fail_now("drain_timeout");
        idle(2);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        exp_cnt = '0;
        exp_cnt_b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] vals[4];
        logic [31:0] seeds[2];
        int k;
        vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF; vals[3] = 32'h1234;
        seeds[0] = 32'h0; seeds[1] = 32'h9E3779B1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_hash", a_hash, 32'h0);
        check("rst_bucket", a_bucket, 5'h0);
        check("rst_tag", a_tag_out, 8'h0);
        check("rst_hash_cnt", a_hash_cnt, 32'h0);
        check("rst_in_ready", a_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Golden corner vectors
        k = 0;
        foreach (vals[c]) foreach (vals[r]) foreach (seeds[s]) begin
            send(vals[c], vals[r], seeds[s], 8'(k));
            k++;
        end
        drain();
        check("cnt_golden", a_hash_cnt, exp_cnt);

        // Latency and throughput
        do_reset();
        lat_mode = 1'b1;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, $urandom, 8'(i));
        drain();
        lat_mode = 1'b0;
        check("latency", 64'(first_out - first_fire), 64'd4);
        check("burst_outputs", 64'(lat_outs), 64'd100);
        check("burst_span", 64'(last_out - first_out), 64'd99);
        check("cnt_burst", a_hash_cnt, 32'd100);

        // Random backpressure with occasional input gaps
        bp_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send($urandom, $urandom, $urandom, 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        bp_mode = 1'b0;
        idle(2);
        check("cnt_backpressure", a_hash_cnt, exp_cnt);

        // Reset with three transactions in flight
        send($urandom, $urandom, $urandom, 8'hA1);
        send($urandom, $urandom, $urandom, 8'hA2);
        send($urandom, $urandom, $urandom, 8'hA3);
        do_reset();
        @(negedge clk);
        check("midrst_out_valid", a_out_valid, 1'b0);
        check("midrst_hash_cnt", a_hash_cnt, 32'h0);
        @(posedge clk);
        #1;
        idle(8);
        send(32'h0042, 32'h0017, 32'hCAFEF00D, 8'h5A);
        drain();
        check("cnt_after_rst", a_hash_cnt, 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut_a.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut_a.cnt_q;
        check("cnt_forced", a_hash_cnt, 32'hFFFFFFFF);
        exp_cnt = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        send($urandom, $urandom, $urandom, 8'h77);
        drain();
        check("cnt_wrap", a_hash_cnt, 32'h0);
        check("cnt_wrap_model", a_hash_cnt, exp_cnt);

        // Full-width index extremes on the 32-bit instance
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8'h01);
        send(32'hFFFFFFFF, 32'h0, 32'h9E3779B1, 8'h00);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, $urandom, 8'h03);
        drain();
        check("b_hash_cnt", b_hash_cnt, exp_cnt_b);
        check("queues_empty", 64'(qa.size() + qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
